// File: rtl/fetch_queue_stage.sv
// rtl/fetch_queue_stage.sv - instruction fetch stage with prefetch queue and redirect flush
// Optional feature macro: FETCH_ALIGN_CHECK_EN (sticky misaligned-redirect halt)
module fetch_queue_stage #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int QUEUE_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   BranchTaken_in,
  input  logic [ADDR_WIDTH-1:0]  BranchTarget_in,
  input  logic                   Jump_in,
  input  logic [25:0]            JumpIndex_in,
  input  logic [ADDR_WIDTH-1:0]  JumpPCPlus4_in,
  input  logic                   JumpReg_in,
  input  logic [ADDR_WIDTH-1:0]  JumpRegTarget_in,
  output logic [ADDR_WIDTH-1:0]  IMemAddr_out,
  output logic                   IMemRdEn_out,
  input  logic [INSTR_WIDTH-1:0] IMemData_in,
  output logic [INSTR_WIDTH-1:0] Instruction_out,
  output logic [ADDR_WIDTH-1:0]  PCPlus4_out,
  output logic                   Valid_out,
  input  logic                   Ready_in,
  output logic                   Misalign_out
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_WIDTH-1:0]  fetch_pc;
  logic [ADDR_WIDTH-1:0]  inflight_pc;
  logic                   inflight;
  logic [INSTR_WIDTH-1:0] q_instr [QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0]  q_pc4   [QUEUE_DEPTH];
  logic [PTR_W-1:0]       head;
  logic [PTR_W-1:0]       tail;
  logic [CNT_W-1:0]       count;

  logic                   redirect;
  logic [ADDR_WIDTH-1:0]  raw_target;
  logic [ADDR_WIDTH-1:0]  target;
  logic [CNT_W-1:0]       occupancy;
  logic                   halted;
  logic                   issue;
  logic                   push;
  logic                   pop;
  logic                   unused_bits;

`ifdef FETCH_ALIGN_CHECK_EN
  logic misalign;
  assign halted       = misalign;
  assign Misalign_out = misalign;
  assign target       = raw_target;
  assign unused_bits  = ^JumpPCPlus4_in[27:0];
`else
  assign halted       = 1'b0;
  assign Misalign_out = 1'b0;
  assign target       = {raw_target[ADDR_WIDTH-1:2], 2'b00};
  assign unused_bits  = ^{JumpPCPlus4_in[27:0], raw_target[1:0]};
`endif

  always_comb begin
    redirect = JumpReg_in | Jump_in | BranchTaken_in;
    if (JumpReg_in)
      raw_target = JumpRegTarget_in;
    else if (Jump_in)
      raw_target = {JumpPCPlus4_in[ADDR_WIDTH-1:28], JumpIndex_in, 2'b00};
    else
      raw_target = BranchTarget_in;
  end

  // Reserve a queue slot for the in-flight read so a response always has room.
  assign occupancy    = count + {{(CNT_W-1){1'b0}}, inflight};
  assign issue        = Rst && !redirect && !halted && (occupancy < CNT_W'(QUEUE_DEPTH));
  assign push         = inflight && !redirect;
  assign Valid_out    = (count != '0);
  assign pop          = Valid_out && Ready_in;

  assign IMemRdEn_out    = issue;
  assign IMemAddr_out    = fetch_pc;
  assign Instruction_out = q_instr[head];
  assign PCPlus4_out     = q_pc4[head];

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      fetch_pc    <= RESET_PC;
      inflight_pc <= '0;
      inflight    <= 1'b0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        q_instr[i] <= '0;
        q_pc4[i]   <= '0;
      end
`ifdef FETCH_ALIGN_CHECK_EN
      misalign    <= 1'b0;
`endif
    end else if (redirect) begin
      fetch_pc <= target;
      inflight <= 1'b0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
      if (raw_target[1:0] != 2'b00)
        misalign <= 1'b1;
`endif
    end else begin
      inflight <= issue;
      if (issue) begin
        fetch_pc    <= fetch_pc + ADDR_WIDTH'(4);
        inflight_pc <= fetch_pc;
      end
      if (push) begin
        q_instr[tail] <= IMemData_in;
        q_pc4[tail]   <= inflight_pc + ADDR_WIDTH'(4);
        tail          <= tail + 1'b1;
      end
      if (pop)
        head <= head + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

endmodule

// File: tb/tb_fetch_queue_stage.sv
// tb/tb_fetch_queue_stage.sv - vector-table bench for fetch_queue_stage
module tb_fetch_queue_stage;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        BranchTaken_in;
  logic [31:0] BranchTarget_in;
  logic        Jump_in;
  logic [25:0] JumpIndex_in;
  logic [31:0] JumpPCPlus4_in;
  logic        JumpReg_in;
  logic [31:0] JumpRegTarget_in;
  logic [31:0] IMemAddr_out;
  logic        IMemRdEn_out;
  logic [31:0] IMemData_in = 32'h0;
  logic [31:0] Instruction_out;
  logic [31:0] PCPlus4_out;
  logic        Valid_out;
  logic        Ready_in;
  logic        Misalign_out;

  fetch_queue_stage dut (
    .Clk(Clk), .Rst(Rst),
    .BranchTaken_in(BranchTaken_in), .BranchTarget_in(BranchTarget_in),
    .Jump_in(Jump_in), .JumpIndex_in(JumpIndex_in), .JumpPCPlus4_in(JumpPCPlus4_in),
    .JumpReg_in(JumpReg_in), .JumpRegTarget_in(JumpRegTarget_in),
    .IMemAddr_out(IMemAddr_out), .IMemRdEn_out(IMemRdEn_out), .IMemData_in(IMemData_in),
    .Instruction_out(Instruction_out), .PCPlus4_out(PCPlus4_out),
    .Valid_out(Valid_out), .Ready_in(Ready_in), .Misalign_out(Misalign_out)
  );

  always #5 Clk = ~Clk;

  // Synchronous memory: word = address | 0xA0000000, one cycle after the strobe.
  always @(posedge Clk)
    if (IMemRdEn_out) IMemData_in <= IMemAddr_out | 32'hA000_0000;

  // rd: 0 none, 1 branch, 2 jr, 3 j, 4 jr+j+branch together
  // hchk: 0 skip head, 1 Valid_out only, 2 Valid_out + head data
  typedef struct {
    logic        rst;
    logic        ready;
    int          rd;
    logic [31:0] tgt;
    logic        rden;
    logic [31:0] addr;
    int          hchk;
    logic        valid;
    logic [31:0] pc4;
  } vec_t;

  vec_t vecs[$];
  int   passed = 0;
  int   total  = 0;

  function automatic vec_t v(input logic rst, input logic ready, input int rd, input logic [31:0] tgt,
                             input logic rden, input logic [31:0] addr, input int hchk,
                             input logic valid, input logic [31:0] pc4);
    vec_t r;
    r.rst = rst; r.ready = ready; r.rd = rd; r.tgt = tgt; r.rden = rden;
    r.addr = addr; r.hchk = hchk; r.valid = valid; r.pc4 = pc4;
    return r;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s [%0d]: got 0x%08h, expected 0x%08h", name, idx, act, exp);
  endtask

  task automatic drive(input logic rst, input logic ready, input int rd, input logic [31:0] tgt);
    Rst              = rst;
    Ready_in         = ready;
    BranchTaken_in   = (rd == 1 || rd == 4);
    JumpReg_in       = (rd == 2 || rd == 4);
    Jump_in          = (rd == 3 || rd == 4);
    BranchTarget_in  = (rd == 4) ? 32'h0000_0300 : tgt;
    JumpRegTarget_in = tgt;
    JumpIndex_in     = 26'h10;
    JumpPCPlus4_in   = 32'h4000_0010;
  endtask

  initial begin
    logic [31:0] exp_instr;
    vecs.push_back(v(0,1,0,32'h0,        0,32'h0,        2,0,32'h0));
    vecs.push_back(v(1,1,0,32'h0,        1,32'h0,        2,0,32'h0));
    vecs.push_back(v(1,1,0,32'h0,        1,32'h4,        1,0,32'h0));
    vecs.push_back(v(1,1,0,32'h0,        1,32'h8,        2,1,32'h4));
    vecs.push_back(v(1,1,0,32'h0,        1,32'hC,        2,1,32'h8));
    vecs.push_back(v(1,1,0,32'h0,        1,32'h10,       2,1,32'hC));
    vecs.push_back(v(0,0,0,32'h0,        0,32'h0,        0,0,32'h0));
    vecs.push_back(v(1,0,0,32'h0,        1,32'h0,        2,0,32'h0));
    vecs.push_back(v(1,0,0,32'h0,        1,32'h4,        1,0,32'h0));
    vecs.push_back(v(1,0,0,32'h0,        1,32'h8,        2,1,32'h4));
    vecs.push_back(v(1,0,0,32'h0,        1,32'hC,        2,1,32'h4));
    vecs.push_back(v(1,0,0,32'h0,        0,32'h0,        2,1,32'h4));
    vecs.push_back(v(1,0,0,32'h0,        0,32'h0,        2,1,32'h4));
    vecs.push_back(v(1,1,0,32'h0,        0,32'h0,        2,1,32'h4));
    vecs.push_back(v(1,1,0,32'h0,        1,32'h10,       2,1,32'h8));
    vecs.push_back(v(1,1,0,32'h0,        1,32'h14,       2,1,32'hC));
    vecs.push_back(v(1,1,0,32'h0,        1,32'h18,       2,1,32'h10));
    vecs.push_back(v(1,1,0,32'h0,        1,32'h1C,       2,1,32'h14));
    vecs.push_back(v(1,0,0,32'h0,        1,32'h20,       2,1,32'h18));
    vecs.push_back(v(1,0,1,32'h100,      0,32'h0,        2,1,32'h18));
    vecs.push_back(v(1,0,0,32'h0,        1,32'h100,      1,0,32'h0));
    vecs.push_back(v(1,0,0,32'h0,        1,32'h104,      1,0,32'h0));
    vecs.push_back(v(1,1,0,32'h0,        1,32'h108,      2,1,32'h104));
    vecs.push_back(v(1,1,4,32'h200,      0,32'h0,        2,1,32'h108));
    vecs.push_back(v(1,1,0,32'h0,        1,32'h200,      1,0,32'h0));
    vecs.push_back(v(1,1,3,32'h0,        0,32'h0,        1,0,32'h0));
    vecs.push_back(v(1,1,0,32'h0,        1,32'h4000_0040,1,0,32'h0));
    vecs.push_back(v(1,1,0,32'h0,        1,32'h4000_0044,1,0,32'h0));
    vecs.push_back(v(1,1,0,32'h0,        1,32'h4000_0048,2,1,32'h4000_0044));
    vecs.push_back(v(1,1,2,32'hFFFF_FFFC,0,32'h0,        2,1,32'h4000_0048));
    vecs.push_back(v(1,1,0,32'h0,        1,32'hFFFF_FFFC,1,0,32'h0));
    vecs.push_back(v(1,1,0,32'h0,        1,32'h0,        1,0,32'h0));
    vecs.push_back(v(1,1,0,32'h0,        1,32'h4,        2,1,32'h0));
    vecs.push_back(v(1,1,0,32'h0,        1,32'h8,        2,1,32'h4));

    drive(0, 1, 0, 32'h0);
    repeat (2) @(posedge Clk);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge Clk);
      drive(vecs[i].rst, vecs[i].ready, vecs[i].rd, vecs[i].tgt);
      #1;
      chk("rden", i, {31'h0, IMemRdEn_out}, {31'h0, vecs[i].rden});
      if (vecs[i].rden) chk("addr", i, IMemAddr_out, vecs[i].addr);
      chk("misalign", i, {31'h0, Misalign_out}, 32'h0);
      if (vecs[i].hchk >= 1) chk("valid", i, {31'h0, Valid_out}, {31'h0, vecs[i].valid});
      if (vecs[i].hchk == 2) begin
        exp_instr = vecs[i].valid ? ((vecs[i].pc4 - 32'h4) | 32'hA000_0000) : 32'h0;
        chk("pc4", i, PCPlus4_out, vecs[i].pc4);
        chk("instr", i, Instruction_out, exp_instr);
      end
    end

    // Misaligned branch target 0x102
    @(negedge Clk);
    drive(1, 1, 1, 32'h102);
    #1;
    chk("mis_rden_redirect", 100, {31'h0, IMemRdEn_out}, 32'h0);
    chk("mis_head_pc4", 100, PCPlus4_out, 32'h8);
    for (int k = 0; k < 5; k++) begin
      @(negedge Clk);
      drive(1, 1, 0, 32'h0);
      #1;
`ifdef FETCH_ALIGN_CHECK_EN
      chk("mis_flag", 101 + k, {31'h0, Misalign_out}, 32'h1);
      chk("mis_halt", 101 + k, {31'h0, IMemRdEn_out}, 32'h0);
`else
      chk("mis_flag", 101 + k, {31'h0, Misalign_out}, 32'h0);
      chk("mis_rden", 101 + k, {31'h0, IMemRdEn_out}, 32'h1);
      chk("mis_addr", 101 + k, IMemAddr_out, 32'h100 + 32'(4 * k));
`endif
    end

    // Reset overrides a simultaneous redirect
    @(negedge Clk);
    drive(0, 1, 1, 32'h500);
    #1;
    chk("rst_rden", 110, {31'h0, IMemRdEn_out}, 32'h0);
    @(negedge Clk);
    drive(1, 1, 0, 32'h0);
    #1;
    chk("rst_misalign", 111, {31'h0, Misalign_out}, 32'h0);
    chk("rst_valid", 111, {31'h0, Valid_out}, 32'h0);
    chk("rst_issue", 111, {31'h0, IMemRdEn_out}, 32'h1);
    chk("rst_addr", 111, IMemAddr_out, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
